// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and constants for the RV32M multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_e;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: one radix-2 step per enable, shift-add multiply or restoring divide
module muldiv_datapath #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_load,
  input  logic                      i_en,
  input  logic                      i_div,
  input  logic [DATA_WIDTH-1:0]     i_a,
  input  logic [DATA_WIDTH-1:0]     i_b,
  output logic [2*DATA_WIDTH-1:0]   o_acc
);
  localparam int W = DATA_WIDTH;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_acc;
  logic [W:0]     w_sum, w_rem, w_diff;
  logic [2*W-1:0] w_mul_next, w_div_next;
  // divide keeps remainder in the high half and shifts quotient bits into the low half
  always_comb begin
    w_sum      = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_rem      = {r_acc[2*W-1:W], r_acc[W-1]};
    w_diff     = w_rem - {1'b0, r_b};
    w_mul_next = {w_sum, r_acc[W-1:1]};
    w_div_next = w_diff[W] ? {w_rem[W-1:0], r_acc[W-2:0], 1'b0}
                           : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_load) begin
      r_b   <= i_b;
      r_acc <= {{W{1'b0}}, i_a};
    end else if (i_en) begin
      r_acc <= i_div ? w_div_next : w_mul_next;
    end
  end
  assign o_acc = r_acc;
endmodule

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative RV32M multiply/divide in Execute; stalls the pipe while iterating
module execute_muldiv
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StartE,
  input  logic                  KillE,
  input  logic [2:0]            Funct3E,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  output logic [DATA_WIDTH-1:0] MulDivResultE,
  output logic                  DoneE,
  output logic                  StallMD
);
  localparam int W = DATA_WIDTH;
  muldiv_state_e  r_state;
  muldiv_op_e     r_op;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic           r_neg_q, r_neg_r, r_special;
  logic [W-1:0]   r_spec_res;
  logic           w_sa, w_sb, w_neg_a, w_neg_b, w_div_zero, w_ovf, w_spec, w_start;
  logic [W-1:0]   w_spec_res, w_res;
  logic [2*W-1:0] w_acc, w_prod;
  always_comb begin
    w_sa       = !(Funct3E inside {OP_MULHU, OP_DIVU, OP_REMU});
    w_sb       = w_sa && Funct3E != OP_MULHSU;
    w_neg_a    = w_sa & SrcAE[W-1];
    w_neg_b    = w_sb & SrcBE[W-1];
    w_div_zero = Funct3E[2] & (SrcBE == '0);
    w_ovf      = Funct3E[2] & ~Funct3E[0] & (SrcAE == INT_MIN) & (SrcBE == '1);
    w_spec     = w_div_zero | w_ovf;
    w_start    = (r_state == IDLE) & StartE & ~KillE;
    w_spec_res = w_div_zero ? (Funct3E[1] ? SrcAE : DIV_ZERO_Q) : (Funct3E[1] ? '0 : INT_MIN);
    w_prod     = r_neg_q ? -w_acc : w_acc;
    w_res      = r_special ? r_spec_res
               : r_op == OP_MUL ? w_prod[W-1:0]
               : r_op inside {OP_MULH, OP_MULHSU, OP_MULHU} ? w_prod[2*W-1:W]
               : r_op inside {OP_DIV, OP_DIVU} ? neg_if(r_neg_q, w_acc[W-1:0])
               : neg_if(r_neg_r, w_acc[2*W-1:W]);
    DoneE         = (r_state == DONE) & ~KillE;
    MulDivResultE = DoneE ? w_res : '0;
    StallMD       = w_start | ((r_state == BUSY) & ~KillE);
  end
  muldiv_datapath #(.DATA_WIDTH(DATA_WIDTH)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start & ~w_spec),
    .i_en   (r_state == BUSY),
    .i_div  (r_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}),
    .i_a    (neg_if(w_neg_a, SrcAE)),
    .i_b    (neg_if(w_neg_b, SrcBE)),
    .o_acc  (w_acc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= OP_MUL;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
    end else if (KillE && r_state != IDLE) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_op       <= muldiv_op_e'(Funct3E);
          r_neg_q    <= w_neg_a ^ w_neg_b;
          r_neg_r    <= w_neg_a;
          r_special  <= w_spec;
          r_spec_res <= w_spec_res;
          r_cnt      <= '0;
          r_state    <= w_spec ? DONE : BUSY;
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Iterative RV32M multiply/divide unit that sits in the Execute stage alongside the ALU. It consumes the operands and op select produced by the decode_execute register, after forwarding muxes. It holds the pipeline stalled while it iterates, then presents a 32-bit result for one cycle so the instruction advances into execute_memory with its result.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- CNT_WIDTH, 5, iteration counter width; equals log2(DATA_WIDTH).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- StartE  in  1  a valid M-extension instruction is in Execute (MulDivE & ~bubble).
- KillE  in  1  abort; same meaning as FlushE on the Execute register.
- Funct3E  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  in  DATA_WIDTH  rs1 operand, post-forwarding.
- SrcBE  in  DATA_WIDTH  rs2 operand, post-forwarding.
- MulDivResultE  out  DATA_WIDTH  result; valid only while DoneE=1, otherwise 0.
- DoneE  out  1  result valid this cycle.
- StallMD  out  1  stall F, D and E registers (OR-ed into hazard unit stalls).

## Operation
- Clock is clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE, counter 0, all datapath registers 0, DoneE 0, StallMD 0, MulDivResultE 0.
- States:
  - IDLE: waiting for an op.
  - BUSY: iterating.
  - DONE: result presented.
- IDLE -> BUSY when StartE & ~KillE & not special-case. Load |A|, |B| (sign per op), latch op, sign flags, counter=0.
- IDLE -> DONE when StartE & ~KillE & special case. Result is loaded directly. Special cases:
  - div/rem by zero: DIV/DIVU quotient all ones; REM/REMU = SrcAE.
  - DIV overflow (0x80000000 / -1): quotient 0x80000000; REM gives 0.
- BUSY: one radix-2 step per cycle. Counter increments each step; after the step with counter==31, go to DONE.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing 32-bit quotient and remainder.
- DONE: result is sign-corrected and DoneE=1 for exactly one cycle, then -> IDLE unconditionally. StartE is ignored in DONE, because the same instruction is still in E.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Sign correction:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- Output selection: MUL returns product[31:0]. MULH* return product[63:32]. DIV* return the quotient. REM* return the remainder.
- StallMD = (IDLE & StartE & ~KillE) | BUSY. StallMD is 0 in DONE, so the instruction leaves E on the DONE edge.
- KillE in BUSY or DONE -> IDLE on the next edge. DoneE is forced to 0 in that cycle and StallMD drops.

## Timing
- Normal op: start sampled at edge 0 (IDLE). BUSY for cycles 1-32. DoneE=1 in cycle 33. Latency is 33 cycles; StallMD is high for cycles 0-32.
- Special case: DoneE=1 in cycle 1; StallMD is high in cycle 0 only.
- Back-to-back: a new StartE is accepted in the IDLE cycle that follows DONE (at the earliest, cycle 34).
- rst_n low mid-op: immediately IDLE, outputs 0, no DoneE.

## Structure
- muldiv_pkg holds:
  - muldiv_op_e enum for Funct3E encodings.
  - muldiv_state_e {IDLE, BUSY, DONE}.
  - constants DIV_ZERO_Q (all ones) and INT_MIN.
- The FSM, counter and sign fix-up stay in execute_muldiv.
- The shared shift/add-subtract datapath is a natural sub-module, muldiv_datapath (one step per enable, with mode select).

## Test plan
- MUL 7 * -3 -> DoneE in cycle 33, result 0xFFFFFFEB; MULH of the same -> 0xFFFFFFFF; StallMD high cycles 0-32.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> quotient 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; REM of the same -> 0. Each has DoneE in cycle 1.
- KillE at cycle 10 of a DIV -> IDLE at cycle 11, DoneE never asserts; a following StartE is accepted normally.
- rst_n pulsed low at cycle 20 of a MUL -> StallMD and DoneE drop immediately. After release, MUL 3 * 4 -> 12 with full 33-cycle latency.
